// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges LSU/MD/EX results onto the single regbank write port
// and tracks pending destination registers. Optional forwarding: WB_FORWARD_EN.
module wb_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            lsu_valid_i,
  output logic            lsu_ready_o,
  input  logic [4:0]      lsu_rd_i,
  input  logic [XLEN-1:0] lsu_data_i,
  input  logic            md_valid_i,
  output logic            md_ready_o,
  input  logic [4:0]      md_rd_i,
  input  logic [XLEN-1:0] md_data_i,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic [4:0]      ex_rd_i,
  input  logic [XLEN-1:0] ex_data_i,
  input  logic            reserve_i,
  input  logic [4:0]      reserve_rd_i,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  output logic            hazard1_o,
  output logic            hazard2_o,
  output logic            rf_we_o,
  output logic [4:0]      rf_rd_o,
  output logic [XLEN-1:0] rf_data_o,
  output logic            busy_o
`ifdef WB_FORWARD_EN
  ,
  output logic            fwd1_o,
  output logic            fwd2_o,
  output logic [XLEN-1:0] fwd_data_o
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [2:0]      valid_s;
  logic [2:0]      forced_s;
  logic [2:0]      gnt_s;
  logic [3:0]      cnt_q [3];
  logic [3:0]      cnt_d [3];
  logic [4:0]      sel_rd_s;
  logic [XLEN-1:0] sel_data_s;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_data_q, rf_data_d;
  logic [31:0]     sb_q, sb_d;
  logic [31:0]     sb_set_s, sb_clr_s;

  // Bit order everywhere: 0 = LSU, 1 = MD, 2 = EX (also the fixed priority order).
  assign valid_s = {ex_valid_i, md_valid_i, lsu_valid_i};

  // Grant selection: starved sources first, then fixed priority.
  always_comb begin
    forced_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      forced_s[i] = valid_s[i] && (cnt_q[i] == LIMIT);
    end
    if (forced_s[0])      gnt_s = 3'b001;
    else if (forced_s[1]) gnt_s = 3'b010;
    else if (forced_s[2]) gnt_s = 3'b100;
    else if (valid_s[0])  gnt_s = 3'b001;
    else if (valid_s[1])  gnt_s = 3'b010;
    else if (valid_s[2])  gnt_s = 3'b100;
    else                  gnt_s = 3'b000;
  end

  // Starvation counters: count lost cycles while waiting, saturating at the limit.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      if (valid_s[i] && !gnt_s[i]) begin
        cnt_d[i] = (cnt_q[i] == LIMIT) ? LIMIT : cnt_q[i] + 4'd1;
      end else begin
        cnt_d[i] = 4'd0;
      end
    end
  end

  assign lsu_ready_o = gnt_s[0];
  assign md_ready_o  = gnt_s[1];
  assign ex_ready_o  = gnt_s[2];

  // Winner's payload mux.
  always_comb begin
    case (gnt_s)
      3'b001:  begin sel_rd_s = lsu_rd_i; sel_data_s = lsu_data_i; end
      3'b010:  begin sel_rd_s = md_rd_i;  sel_data_s = md_data_i;  end
      3'b100:  begin sel_rd_s = ex_rd_i;  sel_data_s = ex_data_i;  end
      default: begin sel_rd_s = 5'd0;     sel_data_s = {XLEN{1'b0}}; end
    endcase
  end

  // An x0 destination completes the handshake but never reaches the bank.
  always_comb begin
    rf_we_d = (|gnt_s) && (sel_rd_s != 5'd0);
    if (rf_we_d) begin
      rf_rd_d   = sel_rd_s;
      rf_data_d = sel_data_s;
    end else begin
      rf_rd_d   = rf_rd_q;
      rf_data_d = rf_data_q;
    end
  end

  // Set is applied after clear so a fresh reservation survives a same-cycle retire.
  assign sb_clr_s = rf_we_q ? (32'd1 << rf_rd_q) : 32'd0;
  assign sb_set_s = (reserve_i && (reserve_rd_i != 5'd0)) ? (32'd1 << reserve_rd_i) : 32'd0;
  assign sb_d     = ((sb_q & ~sb_clr_s) | sb_set_s) & 32'hFFFF_FFFE;

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q   <= 1'b0;
      rf_rd_q   <= 5'd0;
      rf_data_q <= {XLEN{1'b0}};
      sb_q      <= 32'd0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= 4'd0;
      end
    end else begin
      rf_we_q   <= rf_we_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
      sb_q      <= sb_d;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rf_we_o   = rf_we_q;
  assign rf_rd_o   = rf_rd_q;
  assign rf_data_o = rf_data_q;
  assign busy_o    = |sb_q;

`ifdef WB_FORWARD_EN
  logic fwd1_s, fwd2_s;

  assign fwd1_s     = rf_we_q && (rf_rd_q == rs1_i) && (rs1_i != 5'd0);
  assign fwd2_s     = rf_we_q && (rf_rd_q == rs2_i) && (rs2_i != 5'd0);
  assign hazard1_o  = sb_q[rs1_i] & ~fwd1_s;
  assign hazard2_o  = sb_q[rs2_i] & ~fwd2_s;
  assign fwd1_o     = fwd1_s;
  assign fwd2_o     = fwd2_s;
  assign fwd_data_o = rf_data_q;
`else
  assign hazard1_o  = sb_q[rs1_i];
  assign hazard2_o  = sb_q[rs2_i];
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes are queued at stimulus time and
// a negedge monitor checks every regbank write against that queue.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        lsu_valid_i, md_valid_i, ex_valid_i;
  logic        lsu_ready_o, md_ready_o, ex_ready_o;
  logic [4:0]  lsu_rd_i, md_rd_i, ex_rd_i;
  logic [31:0] lsu_data_i, md_data_i, ex_data_i;
  logic        reserve_i;
  logic [4:0]  reserve_rd_i, rs1_i, rs2_i;
  logic        hazard1_o, hazard2_o, rf_we_o, busy_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_data_o;
`ifdef WB_FORWARD_EN
  logic        fwd1_o, fwd2_o;
  logic [31:0] fwd_data_o;
`endif

  int total = 0;
  int bad   = 0;
  logic [36:0] exp_q [$];

  wb_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
    .md_valid_i(md_valid_i),   .md_ready_o(md_ready_o),   .md_rd_i(md_rd_i),   .md_data_i(md_data_i),
    .ex_valid_i(ex_valid_i),   .ex_ready_o(ex_ready_o),   .ex_rd_i(ex_rd_i),   .ex_data_i(ex_data_i),
    .reserve_i(reserve_i), .reserve_rd_i(reserve_rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .hazard1_o(hazard1_o), .hazard2_o(hazard2_o),
    .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_data_o(rf_data_o), .busy_o(busy_o)
`ifdef WB_FORWARD_EN
    , .fwd1_o(fwd1_o), .fwd2_o(fwd2_o), .fwd_data_o(fwd_data_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back({rd, data});
  endtask

  // Monitor: every regbank write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rf_we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%08h expected no write", rf_rd_o, rf_data_o);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("wb_rd", {27'd0, rf_rd_o}, {27'd0, e[36:32]});
        chk("wb_data", rf_data_o, e[31:0]);
      end
    end
  end

  initial begin
    reset = 1'b1;
    lsu_valid_i = 1'b0; md_valid_i = 1'b0; ex_valid_i = 1'b0;
    lsu_rd_i = 5'd0; md_rd_i = 5'd0; ex_rd_i = 5'd0;
    lsu_data_i = 32'd0; md_data_i = 32'd0; ex_data_i = 32'd0;
    reserve_i = 1'b0; reserve_rd_i = 5'd0; rs1_i = 5'd0; rs2_i = 5'd0;
    tick();
    tick();
    chk("rst_we", {31'd0, rf_we_o}, 32'd0);
    chk("rst_rd", {27'd0, rf_rd_o}, 32'd0);
    chk("rst_data", rf_data_o, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    reset = 1'b0;

    // Reserve x5, EX writes it back.
    reserve_i = 1'b1; reserve_rd_i = 5'd5;
    tick();
    reserve_i = 1'b0; rs1_i = 5'd5;
    ex_valid_i = 1'b1; ex_rd_i = 5'd5; ex_data_i = 32'hDEADBEEF;
    #1;
    chk("t1_ex_ready", {31'd0, ex_ready_o}, 32'd1);
    chk("t1_haz_pending", {31'd0, hazard1_o}, 32'd1);
    chk("t1_busy", {31'd0, busy_o}, 32'd1);
    push(5'd5, 32'hDEADBEEF);
    tick();
    ex_valid_i = 1'b0;
    #1;
    chk("t1_we", {31'd0, rf_we_o}, 32'd1);
`ifdef WB_FORWARD_EN
    chk("t1_haz_wb_fwd", {31'd0, hazard1_o}, 32'd0);
`else
    chk("t1_haz_wb", {31'd0, hazard1_o}, 32'd1);
`endif
    tick();
    chk("t1_haz_after", {31'd0, hazard1_o}, 32'd0);
    chk("t1_busy_after", {31'd0, busy_o}, 32'd0);
    chk("t1_we_single", {31'd0, rf_we_o}, 32'd0);

    // Three sources at once: fixed priority LSU, MD, EX.
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd1; lsu_data_i = 32'h0000_0011;
    md_valid_i  = 1'b1; md_rd_i  = 5'd2; md_data_i  = 32'h0000_0022;
    ex_valid_i  = 1'b1; ex_rd_i  = 5'd3; ex_data_i  = 32'h0000_0033;
    #1;
    chk("t2_c0_rdy", {29'd0, ex_ready_o, md_ready_o, lsu_ready_o}, 32'b001);
    push(5'd1, 32'h11); push(5'd2, 32'h22); push(5'd3, 32'h33);
    tick();
    lsu_valid_i = 1'b0;
    #1;
    chk("t2_c1_rdy", {29'd0, ex_ready_o, md_ready_o, lsu_ready_o}, 32'b010);
    tick();
    md_valid_i = 1'b0;
    #1;
    chk("t2_c2_rdy", {29'd0, ex_ready_o, md_ready_o, lsu_ready_o}, 32'b100);
    tick();
    ex_valid_i = 1'b0;
    tick();

    // LSU streams every cycle; EX is forced in after 4 lost cycles.
    ex_valid_i = 1'b1; ex_rd_i = 5'd10; ex_data_i = 32'hE0E0_E0E0;
    for (int k = 0; k < 4; k++) begin
      lsu_valid_i = 1'b1; lsu_rd_i = 5'(11 + k); lsu_data_i = 32'h1000 + 32'(k);
      #1;
      chk("t3_lsu_wins", {31'd0, lsu_ready_o}, 32'd1);
      chk("t3_ex_waits", {31'd0, ex_ready_o}, 32'd0);
      push(5'(11 + k), 32'h1000 + 32'(k));
      tick();
    end
    lsu_rd_i = 5'd15; lsu_data_i = 32'h1004;
    #1;
    chk("t3_ex_forced", {31'd0, ex_ready_o}, 32'd1);
    chk("t3_lsu_held", {31'd0, lsu_ready_o}, 32'd0);
    push(5'd10, 32'hE0E0_E0E0);
    tick();
    ex_valid_i = 1'b0;
    #1;
    chk("t3_lsu_resume", {31'd0, lsu_ready_o}, 32'd1);
    push(5'd15, 32'h1004);
    tick();
    lsu_valid_i = 1'b0;
    tick();

    // rd=0 completes the handshake without a write.
    reserve_i = 1'b1; reserve_rd_i = 5'd20;
    tick();
    reserve_i = 1'b0;
    ex_valid_i = 1'b1; ex_rd_i = 5'd0; ex_data_i = 32'h1234;
    #1;
    chk("t4_ex_ready", {31'd0, ex_ready_o}, 32'd1);
    tick();
    ex_valid_i = 1'b0;
    #1;
    chk("t4_no_we", {31'd0, rf_we_o}, 32'd0);
    chk("t4_busy_kept", {31'd0, busy_o}, 32'd1);
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd20; lsu_data_i = 32'h2020;
    push(5'd20, 32'h2020);
    tick();
    lsu_valid_i = 1'b0;
    tick();
    chk("t4_busy_clear", {31'd0, busy_o}, 32'd0);

    // Retire of x7 coincides with a new reservation of x7.
    reserve_i = 1'b1; reserve_rd_i = 5'd7;
    tick();
    reserve_i = 1'b0;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd7; lsu_data_i = 32'h77;
    push(5'd7, 32'h77);
    tick();
    lsu_valid_i = 1'b0;
    reserve_i = 1'b1; reserve_rd_i = 5'd7; rs2_i = 5'd7;
    #1;
    chk("t5_we", {31'd0, rf_we_o}, 32'd1);
    tick();
    reserve_i = 1'b0;
    #1;
    chk("t5_set_wins", {31'd0, hazard2_o}, 32'd1);
    chk("t5_busy", {31'd0, busy_o}, 32'd1);
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd7; lsu_data_i = 32'h78;
    push(5'd7, 32'h78);
    tick();
    lsu_valid_i = 1'b0;
    tick();
    chk("t5_haz_clear", {31'd0, hazard2_o}, 32'd0);
    chk("t5_rs0_no_haz", {31'd0, hazard1_o}, 32'd0);

    // Writeback of x9 while decode reads x9.
    reserve_i = 1'b1; reserve_rd_i = 5'd9;
    tick();
    reserve_i = 1'b0;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd9; lsu_data_i = 32'hA5A5_A5A5;
    push(5'd9, 32'hA5A5_A5A5);
    tick();
    lsu_valid_i = 1'b0; rs1_i = 5'd9;
    #1;
`ifdef WB_FORWARD_EN
    chk("t6_haz_fwd", {31'd0, hazard1_o}, 32'd0);
    chk("t6_fwd1", {31'd0, fwd1_o}, 32'd1);
    chk("t6_fwd_data", fwd_data_o, 32'hA5A5_A5A5);
`else
    chk("t6_haz_raw", {31'd0, hazard1_o}, 32'd1);
`endif
    tick();
    chk("t6_haz_after", {31'd0, hazard1_o}, 32'd0);

    // Reset on the acceptance cycle drops the write and the scoreboard.
    reserve_i = 1'b1; reserve_rd_i = 5'd3;
    tick();
    reserve_i = 1'b0;
    reset = 1'b1;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd3; lsu_data_i = 32'h3333;
    tick();
    reset = 1'b0; lsu_valid_i = 1'b0;
    #1;
    chk("t7_we_dropped", {31'd0, rf_we_o}, 32'd0);
    chk("t7_busy_reset", {31'd0, busy_o}, 32'd0);
    tick();
    chk("t7_no_late_we", {31'd0, rf_we_o}, 32'd0);

    tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
